dequant_shift: RTL and testbench
================================

DEQUANT_SHIFT -- requirements
Module: dequant_shift

Interface
REQ-001 SHALL have parameter WIDTH_DATA_ADD, default 32: output accumulator-domain width.
REQ-002 SHALL have parameter WIDTH_IN, default 16: signed quantized input width.
REQ-003 SHALL have parameter CH_NUM, default 16: shift-table depth (channels), power of two.
REQ-004 SHALL have parameter SHIFT_W, default 5: shift-amount width (0..31).
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cfg_we  input  1  shift-table write strobe.
REQ-008 cfg_addr  input  log2(CH_NUM)  table write address.
REQ-009 cfg_shift  input  SHIFT_W  left-shift amount written.
REQ-010 cfg_ch_max  input  log2(CH_NUM)  last channel index of the channel walk.
REQ-011 in_valid / in_ready  input / output  1 each  input handshake.
REQ-012 in_data  input  WIDTH_IN  signed quantized sample; in_last  input  1  final beat of pixel.
REQ-013 out_valid / out_ready  output / input  1 each  output handshake.
REQ-014 out_data  output  WIDTH_DATA_ADD  signed dequantized value; out_ch  output  log2(CH_NUM)  channel of beat; out_last  output  1  forwarded in_last.
REQ-015 ovf_cnt  output  16  saturation-event counter.

Function
REQ-016 Input beat SHALL be accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
REQ-017 Two-stage pipeline: S1 registers in_data, looked-up shift, channel, last; S2 registers shifted result; latency from acceptance to out_valid SHALL be 2 cycles with no stall.
REQ-018 Each stage SHALL advance when downstream stage is empty or advancing; in_ready = !S1_valid || S1 advancing; no beat dropped or duplicated; order preserved; full throughput 1 beat/cycle.
REQ-019 Channel counter SHALL start at 0, increment per accepted beat, wrap to 0 after cfg_ch_max; accepted beat with in_last SHALL force next channel to 0.
REQ-020 Counter above a newly lowered cfg_ch_max SHALL wrap to 0 on next acceptance.
REQ-021 Shift lookup SHALL occur at acceptance using table[channel]; cfg_we write to same address in same cycle SHALL return the old value (read-before-write); new value used from the next acceptance.
REQ-022 Result = sign-extend(in_data) arithmetically left-shifted by shift, computed at WIDTH_IN+31 bits before reduction to WIDTH_DATA_ADD.
REQ-023 out_data, out_ch, out_last SHALL hold stable while out_valid && !out_ready.

Reset
REQ-024 While rst high: S1/S2 valid = 0, out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, channel counter = 0, ovf_cnt = 0, all table entries = 0.
REQ-025 in_ready SHALL be 0 during rst and 1 the cycle after release; reset mid-stream SHALL discard all in-flight beats.

Configuration
REQ-026 Macro DEQUANT_SAT_EN defined: results exceeding signed WIDTH_DATA_ADD range SHALL clamp to 0x7FFFFFFF / 0x80000000; ovf_cnt SHALL increment per clamped beat on S2 load, sticking at 0xFFFF.
REQ-027 DEQUANT_SAT_EN undefined: result SHALL be truncated to low WIDTH_DATA_ADD bits (wrap); ovf_cnt tied to 0.

Structure
REQ-028 WIDTH_DATA_ADD, WIDTH_IN, CH_NUM, SHIFT_W defaults and SAT_MAX/SAT_MIN constants SHALL live in the shared parameter header used by the quantization blocks.
REQ-029 Shift-and-clamp arithmetic SHALL be one combinational sub-module, dequant_sat_unit; table, counter, pipeline and handshake stay in dequant_shift.

Verification
REQ-030 table[0]=4, in_data 0x0003, out_ready=1 -> out_data 0x00000030, out_ch 0, out_valid exactly 2 cycles after acceptance.
REQ-031 table[0]=3, in_data 0xFFFE -> out_data 0xFFFFFFF0.
REQ-032 table[0]=20, in_data 0x7FFF -> SAT_EN: 0x7FFFFFFF, ovf_cnt 1; without: 0xFFF00000, ovf_cnt 0.
REQ-033 cfg_ch_max=2, table 1,2,3, four beats of 0x0001 -> out_data 2,4,8,2, out_ch 0,1,2,0; in_last on beat 2 -> beat 3 out_ch 0.
REQ-034 out_ready low 5 cycles, 4 beats offered back-to-back -> exactly 2 accepted then in_ready 0; after release all 4 emerge in order, none lost.
REQ-035 rst asserted with 2 beats in flight -> out_valid 0 next cycle, ovf_cnt 0, table reads 0 shift afterwards.

Source files
------------

// File: rtl/dequant_shift_pkg.sv
// Shared parameter header for the quantization blocks: default widths and
// saturation bounds for the accumulator domain.
package dequant_shift_pkg;

    localparam int DQ_WIDTH_DATA_ADD = 32;
    localparam int DQ_WIDTH_IN       = 16;
    localparam int DQ_CH_NUM         = 16;
    localparam int DQ_SHIFT_W        = 5;

    localparam logic [DQ_WIDTH_DATA_ADD-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DQ_WIDTH_DATA_ADD-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/dequant_sat_unit.sv
// Combinational sign-extend / left-shift / reduce. With DEQUANT_SAT_EN the
// result clamps to the signed output range, otherwise it wraps.
module dequant_sat_unit
    import dequant_shift_pkg::*;
#(
    parameter int WIDTH_DATA_ADD = DQ_WIDTH_DATA_ADD,
    parameter int WIDTH_IN       = DQ_WIDTH_IN,
    parameter int SHIFT_W        = DQ_SHIFT_W
) (
    input  logic [WIDTH_IN-1:0]       data,
    input  logic [SHIFT_W-1:0]        shift,
    output logic [WIDTH_DATA_ADD-1:0] result,
    output logic                      clamped
);

    // Wide enough that any 0..31 shift of the input is exact.
    localparam int WIDE = WIDTH_IN + 31;

    logic [WIDE-1:0] ext;
    logic [WIDE-1:0] shifted;

    assign ext     = {{31{data[WIDTH_IN-1]}}, data};
    assign shifted = $unsigned($signed(ext) <<< shift);

`ifdef DEQUANT_SAT_EN
    localparam logic [WIDTH_DATA_ADD-1:0] MAX_V = {1'b0, {(WIDTH_DATA_ADD-1){1'b1}}};
    localparam logic [WIDTH_DATA_ADD-1:0] MIN_V = {1'b1, {(WIDTH_DATA_ADD-1){1'b0}}};

    logic fits;

    // In range iff every bit above the output sign bit copies it.
    assign fits = (&shifted[WIDE-1:WIDTH_DATA_ADD-1]) | ~(|shifted[WIDE-1:WIDTH_DATA_ADD-1]);

    always_comb begin
        clamped = !fits;
        result  = shifted[WIDTH_DATA_ADD-1:0];
        if (!fits)
            result = shifted[WIDE-1] ? MIN_V : MAX_V;
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[WIDE-1:WIDTH_DATA_ADD];
    assign result    = shifted[WIDTH_DATA_ADD-1:0];
    assign clamped   = 1'b0;
`endif

endmodule

// File: rtl/dequant_shift.sv
// Per-channel dequantizing left shift: shift table, channel walk, two-stage
// valid/ready pipeline. Macro DEQUANT_SAT_EN enables clamping and ovf_cnt.
module dequant_shift
    import dequant_shift_pkg::*;
#(
    parameter int WIDTH_DATA_ADD = DQ_WIDTH_DATA_ADD,
    parameter int WIDTH_IN       = DQ_WIDTH_IN,
    parameter int CH_NUM         = DQ_CH_NUM,
    parameter int SHIFT_W        = DQ_SHIFT_W,
    localparam int AW            = $clog2(CH_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic [AW-1:0]             cfg_ch_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH_IN-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH_DATA_ADD-1:0] out_data,
    output logic [AW-1:0]             out_ch,
    output logic                      out_last,
    output logic [15:0]               ovf_cnt
);

    logic [SHIFT_W-1:0] tbl [CH_NUM];
    logic [AW-1:0]      ch;

    logic                s1_valid;
    logic [WIDTH_IN-1:0] s1_data;
    logic [SHIFT_W-1:0]  s1_shift;
    logic [AW-1:0]       s1_ch;
    logic                s1_last;

    logic                      s2_adv;
    logic                      s1_adv;
    logic                      accept;
    logic [WIDTH_DATA_ADD-1:0] sat_result;
    logic                      clamped;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    // Table read at acceptance sees the pre-write entry on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_NUM; i++)
                tbl[i] <= '0;
            ch       <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
            s1_ch    <= '0;
            s1_last  <= 1'b0;
        end else begin
            if (cfg_we)
                tbl[cfg_addr] <= cfg_shift;
            if (accept) begin
                s1_data  <= in_data;
                s1_shift <= tbl[ch];
                s1_ch    <= ch;
                s1_last  <= in_last;
                // >= also folds a counter stranded above a lowered max back to 0
                ch <= (in_last || ch >= cfg_ch_max) ? '0 : ch + 1'b1;
            end
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
        end
    end

    dequant_sat_unit #(
        .WIDTH_DATA_ADD (WIDTH_DATA_ADD),
        .WIDTH_IN       (WIDTH_IN),
        .SHIFT_W        (SHIFT_W)
    ) u_sat (
        .data    (s1_data),
        .shift   (s1_shift),
        .result  (sat_result),
        .clamped (clamped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_result;
                out_ch   <= s1_ch;
                out_last <= s1_last;
            end
        end
    end

`ifdef DEQUANT_SAT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt <= '0;
        else if (s1_adv && clamped && ovf_cnt != 16'hFFFF)
            ovf_cnt <= ovf_cnt + 16'd1;
    end
`else
    logic unused_clamped;

    assign unused_clamped = clamped;
    assign ovf_cnt        = '0;
`endif

endmodule

// File: tb/tb_dequant_shift.sv
// Randomized self-checking bench for dequant_shift against a queue-based
// arithmetic reference model.
module tb_dequant_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [4:0]  cfg_shift;
    logic [3:0]  cfg_ch_max;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ch;
    logic        out_last;
    logic [15:0] ovf_cnt;

    dequant_shift dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_shift  (cfg_shift),
        .cfg_ch_max (cfg_ch_max),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  ch;
        logic        l;
    } exp_t;

    // Reference model state
    exp_t q[$];
    int   m_tbl [16];
    int   m_ch;
    int   m_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-cycle observations
    logic        acc, xfr, exp_ok;
    logic [31:0] got_d;
    logic [3:0]  got_ch;
    logic        got_l;
    logic        got_valid;
    exp_t        e;

    function automatic logic [31:0] ref_dq(input logic [15:0] d, input int sh, output bit clamp);
        longint v;
        v = longint'($signed(d)) * (longint'(1) << sh);
        clamp = 1'b0;
`ifdef DEQUANT_SAT_EN
        if (v > 64'sd2147483647) begin
            clamp = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (v < -64'sd2147483648) begin
            clamp = 1'b1;
            return 32'h8000_0000;
        end
`endif
        return v[31:0];
    endfunction

    // Sample just after the negedge drive, update the model, then step one clock.
    task automatic tick();
        logic [31:0] r;
        bit          c;
        exp_t        t;
        #1;
        acc       = in_valid && in_ready && !rst;
        xfr       = out_valid && out_ready && !rst;
        got_valid = out_valid;
        got_d     = out_data;
        got_ch    = out_ch;
        got_l     = out_last;
        exp_ok    = 1'b0;
        if (rst) begin
            q.delete();
            foreach (m_tbl[i]) m_tbl[i] = 0;
            m_ch  = 0;
            m_ovf = 0;
        end else begin
            if (xfr && q.size() > 0) begin
                e = q.pop_front();
                exp_ok = 1'b1;
            end
            if (acc) begin
                r = ref_dq(in_data, m_tbl[m_ch], c);
                t.d = r; t.ch = 4'(m_ch); t.l = in_last;
                q.push_back(t);
                if (c && m_ovf != 65535) m_ovf++;
                m_ch = (in_last || m_ch >= int'(cfg_ch_max)) ? 0 : m_ch + 1;
            end
            if (cfg_we) m_tbl[cfg_addr] = int'(cfg_shift);
        end
        @(negedge clk);
    endtask

    task automatic write_tbl(input logic [3:0] a, input logic [4:0] s);
        cfg_we = 1'b1; cfg_addr = a; cfg_shift = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_assert += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        if (out_ch !== 4'h0) begin n_fail++; $display("FAIL reset_out_ch: got %h expected 0", out_ch); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        if (ovf_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovf_cnt: got %h expected 0", ovf_cnt); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_assert++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [4:0]  sh [3];
        logic [15:0] dv [3];
        logic [31:0] ev [3];
        int n;
        sh[0] = 5'd4;  dv[0] = 16'h0003; ev[0] = 32'h0000_0030;
        sh[1] = 5'd3;  dv[1] = 16'hFFFE; ev[1] = 32'hFFFF_FFF0;
        sh[2] = 5'd20; dv[2] = 16'h7FFF;
`ifdef DEQUANT_SAT_EN
        ev[2] = 32'h7FFF_FFFF;
`else
        ev[2] = 32'hFFF0_0000;
`endif
        cfg_ch_max = 4'd0;
        out_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            write_tbl(4'd0, sh[k]);
            in_valid = 1'b1; in_data = dv[k]; in_last = 1'b1;
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            n_assert++;
            if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept[%0d]: got %b expected 1", k, acc); end
            n = 0;
            do begin tick(); n++; end while (!xfr && n < 8);
            n_assert += 4;
            if (n !== 2) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 2", k, n); end
            if (got_d !== ev[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", k, got_d, ev[k]); end
            if (got_ch !== 4'd0) begin n_fail++; $display("FAIL basic_ch[%0d]: got %h expected 0", k, got_ch); end
            if (!exp_ok || got_d !== e.d) begin n_fail++; $display("FAIL basic_model[%0d]: got %h expected %h", k, got_d, e.d); end
        end
        n_assert++;
`ifdef DEQUANT_SAT_EN
        if (ovf_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_ovf: got %0d expected 1", ovf_cnt); end
`else
        if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_ovf: got %0d expected 0", ovf_cnt); end
`endif
    endtask

    task automatic test_channel_walk();
        logic        lasts [8];
        logic [3:0]  ech   [8];
        logic [31:0] edat  [8];
        int bi, oi;
        lasts = '{0, 0, 0, 0, 0, 0, 1, 0};
        ech   = '{0, 1, 2, 0, 1, 2, 0, 0};
        edat  = '{2, 4, 8, 2, 4, 8, 2, 2};
        cfg_ch_max = 4'd2;
        write_tbl(4'd0, 5'd1);
        write_tbl(4'd1, 5'd2);
        write_tbl(4'd2, 5'd3);
        out_ready = 1'b1;
        bi = 0; oi = 0;
        for (int c = 0; c < 30 && oi < 8; c++) begin
            in_valid = (bi < 8);
            in_data  = 16'h0001;
            in_last  = (bi < 8) ? lasts[bi] : 1'b0;
            tick();
            if (acc) bi++;
            if (xfr) begin
                n_assert += 2;
                if (got_d !== edat[oi] || got_ch !== ech[oi])
                    begin n_fail++; $display("FAIL walk_beat[%0d]: got %h/ch%0d expected %h/ch%0d", oi, got_d, got_ch, edat[oi], ech[oi]); end
                if (!exp_ok || got_d !== e.d || got_ch !== e.ch || got_l !== e.l)
                    begin n_fail++; $display("FAIL walk_model[%0d]: got %h/ch%0d/l%b expected %h/ch%0d/l%b", oi, got_d, got_ch, got_l, e.d, e.ch, e.l); end
                oi++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_assert++;
        if (oi !== 8) begin n_fail++; $display("FAIL walk_count: got %0d expected 8", oi); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bp [4];
        int nacc, nout;
        logic        pstall;
        logic [31:0] pd;
        logic [3:0]  pch;
        logic        pl;
        foreach (bp[i]) bp[i] = 16'($urandom_range(0, 255));
        out_ready = 1'b0;
        nacc = 0; nout = 0; pstall = 1'b0; pd = '0; pch = '0; pl = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (nacc < 4);
            in_data  = bp[nacc < 4 ? nacc : 3];
            tick();
            if (acc) nacc++;
            if (pstall) begin
                n_assert++;
                if (got_d !== pd || got_ch !== pch || got_l !== pl)
                    begin n_fail++; $display("FAIL hold_stable: got %h/%0d/%b expected %h/%0d/%b", got_d, got_ch, got_l, pd, pch, pl); end
            end
            pstall = got_valid; pd = got_d; pch = got_ch; pl = got_l;
        end
        n_assert += 2;
        if (nacc !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", nacc); end
        #1;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && nout < 4; c++) begin
            in_valid = (nacc < 4);
            in_data  = bp[nacc < 4 ? nacc : 3];
            tick();
            if (acc) nacc++;
            if (xfr) begin
                n_assert++;
                if (!exp_ok || got_d !== e.d || got_ch !== e.ch)
                    begin n_fail++; $display("FAIL bp_order[%0d]: got %h/ch%0d expected %h/ch%0d", nout, got_d, got_ch, e.d, e.ch); end
                nout++;
            end
        end
        in_valid = 1'b0;
        n_assert++;
        if (nout !== 4 || q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d out, %0d left expected 4, 0", nout, q.size()); end
    endtask

    task automatic test_random();
        int nx;
        cfg_ch_max = 4'($urandom_range(0, 15));
        nx = 0;
        for (int c = 0; c < 400; c++) begin
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 4'($urandom_range(0, 15));
            cfg_shift = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 63) == 0) cfg_ch_max = 4'($urandom_range(0, 15));
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 16'($urandom);
                in_last  = ($urandom_range(0, 7) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (xfr) begin
                nx++;
                n_assert++;
                if (!exp_ok || got_d !== e.d || got_ch !== e.ch || got_l !== e.l)
                    begin n_fail++; $display("FAIL rand_beat[%0d]: got %h/ch%0d/l%b expected %h/ch%0d/l%b", nx, got_d, got_ch, got_l, e.d, e.ch, e.l); end
            end
        end
        cfg_we = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && (q.size() > 0 || out_valid); c++) begin
            tick();
            if (xfr) begin
                n_assert++;
                if (!exp_ok || got_d !== e.d || got_ch !== e.ch || got_l !== e.l)
                    begin n_fail++; $display("FAIL rand_drain: got %h/ch%0d expected %h/ch%0d", got_d, got_ch, e.d, e.ch); end
            end
        end
        n_assert += 2;
        if (q.size() != 0) begin n_fail++; $display("FAIL rand_lost: got %0d pending expected 0", q.size()); end
        if (ovf_cnt !== 16'(m_ovf)) begin n_fail++; $display("FAIL rand_ovf: got %0d expected %0d", ovf_cnt, m_ovf); end
    endtask

    task automatic test_mid_reset();
        int nacc, n;
        write_tbl(4'd0, 5'd7);
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 6 && nacc < 2; c++) begin
            in_valid = 1'b1; in_data = 16'($urandom_range(1, 100)); in_last = 1'b0;
            tick();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_assert += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
        if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_ovf: got %0d expected 0", ovf_cnt); end
        if (nacc !== 2) begin n_fail++; $display("FAIL mrst_inflight: got %0d expected 2", nacc); end
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h0005; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!xfr && n < 8);
        n_assert += 2;
        if (got_d !== 32'h5 || got_ch !== 4'd0) begin n_fail++; $display("FAIL mrst_zero_shift: got %h/ch%0d expected 5/ch0", got_d, got_ch); end
        if (!exp_ok || got_d !== e.d) begin n_fail++; $display("FAIL mrst_model: got %h expected %h", got_d, e.d); end
        tick();
        n_assert++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_no_ghost: got %b expected 0", out_valid); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0; cfg_ch_max = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        acc = 1'b0; xfr = 1'b0; exp_ok = 1'b0; got_valid = 1'b0;
        got_d = '0; got_ch = '0; got_l = 1'b0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
        m_ch = 0; m_ovf = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_channel_walk();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
